// File: rtl/serdes_frame_aligner.sv
// serdes_frame_aligner
// Hunts for a sync word in a serial bit stream, locks byte alignment and
// deserialises the following frames into parallel bytes. With parity mode on,
// each frame carries a trailing even-parity bit. Lock drops after a run of
// consecutive parity errors.
module serdes_frame_aligner #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = 8'hA5,
  parameter int                ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              bit_valid,
  input  logic              par_en,
  input  logic              realign,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              par_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(ERR_LIMIT);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nx;
  logic [ERR_W-1:0]  err_cnt;
  logic [ERR_W-1:0]  err_cnt_nx;
  logic              par_mode;
  logic              par_mode_nx;
  logic [DATA_W-1:0] data_out_nx;
  logic              data_valid_nx;
  logic              par_err_nx;

  // Shifted view of the register including the incoming bit; shared by the
  // hunt comparison and the data path.
  logic [DATA_W-1:0] shifted;
  // Odd number of ones across the collected byte plus the parity bit.
  logic              parity_bad;
  // Error count after one more error, saturating at ERR_LIMIT.
  logic [ERR_W-1:0]  err_inc;

  assign shifted    = {sr[DATA_W-2:0], ser_in};
  assign parity_bad = ^{sr, ser_in};
  assign err_inc    = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);

  // Next-state logic: realign overrides everything, idle cycles hold state.
  always_comb begin
    state_nx      = state;
    sr_nx         = sr;
    bit_cnt_nx    = bit_cnt;
    err_cnt_nx    = err_cnt;
    par_mode_nx   = par_mode;
    data_out_nx   = data_out;
    data_valid_nx = 1'b0;
    par_err_nx    = 1'b0;

    if (realign) begin
      // Drop any partial frame without delivering it.
      state_nx   = HUNT;
      sr_nx      = '0;
      bit_cnt_nx = '0;
      err_cnt_nx = '0;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          sr_nx = shifted;
          if (shifted == SYNC_WORD) begin
            state_nx    = DATA;
            bit_cnt_nx  = '0;
            err_cnt_nx  = '0;
            par_mode_nx = par_en;
          end
        end

        DATA: begin
          sr_nx = shifted;
          if (bit_cnt == LAST_BIT) begin
            if (par_mode) begin
              // Byte complete; wait for the trailing parity bit.
              state_nx   = PARITY;
              bit_cnt_nx = bit_cnt + CNT_W'(1);
            end else begin
              // Frame boundary: deliver and start the next frame with no gap.
              data_out_nx   = shifted;
              data_valid_nx = 1'b1;
              bit_cnt_nx    = '0;
              par_mode_nx   = par_en;
            end
          end else begin
            bit_cnt_nx = bit_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          // The byte is delivered whatever the parity outcome.
          data_out_nx   = sr;
          data_valid_nx = 1'b1;
          bit_cnt_nx    = '0;
          if (parity_bad) begin
            par_err_nx = 1'b1;
            err_cnt_nx = err_inc;
            if (err_inc == ERR_MAX) begin
              // Too many consecutive errors: alignment is presumed lost.
              state_nx = HUNT;
              sr_nx    = '0;
            end else begin
              state_nx    = DATA;
              par_mode_nx = par_en;
            end
          end else begin
            err_cnt_nx  = '0;
            state_nx    = DATA;
            par_mode_nx = par_en;
          end
        end

        default: begin
          state_nx   = HUNT;
          sr_nx      = '0;
          bit_cnt_nx = '0;
          err_cnt_nx = '0;
        end
      endcase
    end
  end

  // State and registered outputs; locked follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      err_cnt    <= '0;
      par_mode   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      bit_cnt    <= bit_cnt_nx;
      err_cnt    <= err_cnt_nx;
      par_mode   <= par_mode_nx;
      data_out   <= data_out_nx;
      data_valid <= data_valid_nx;
      par_err    <= par_err_nx;
      locked     <= (state_nx != HUNT);
    end
  end

endmodule

// File: tb/tb_serdes_frame_aligner.sv
// Directed bench for serdes_frame_aligner. A bit-queue model of the framing
// rules predicts every output each cycle; literal expectations pin the model.
module tb_serdes_frame_aligner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       realign = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       par_err;
  logic       locked;

  int tests = 0;
  int fails = 0;

  serdes_frame_aligner dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .bit_valid  (bit_valid),
    .par_en     (par_en),
    .realign    (realign),
    .data_out   (data_out),
    .data_valid (data_valid),
    .par_err    (par_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Model state: a window of the last hunt bits, and the bits of the frame
  // currently being collected while locked.
  int         m_hunt = 0;
  bit         fq[$];
  bit         m_locked = 0;
  bit         m_pmode = 0;
  int         m_errs = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_dv = 0;
  bit         m_pe = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  task automatic model_reset();
    m_hunt = 0; fq.delete(); m_locked = 0; m_pmode = 0; m_errs = 0;
    m_data = 8'h00; m_dv = 0; m_pe = 0;
  endtask

  // Apply the inputs that the last rising edge sampled.
  task automatic model_apply();
    int val;
    int ones;
    m_dv = 0;
    m_pe = 0;
    if (realign) begin
      m_locked = 0; m_hunt = 0; fq.delete(); m_errs = 0;
    end else if (bit_valid) begin
      if (!m_locked) begin
        m_hunt = ((m_hunt << 1) | int'(ser_in)) & 255;
        if (m_hunt == 'hA5) begin
          m_locked = 1; m_pmode = par_en; fq.delete(); m_errs = 0;
        end
      end else begin
        fq.push_back(ser_in);
        if (fq.size() == 8 + (m_pmode ? 1 : 0)) begin
          val = 0;
          ones = 0;
          for (int i = 0; i < 8; i++) val = val * 2 + int'(fq[i]);
          for (int i = 0; i < fq.size(); i++) ones += int'(fq[i]);
          m_data = val[7:0];
          m_dv = 1;
          if (m_pmode && (ones % 2 == 1)) begin
            m_pe = 1;
            m_errs++;
            if (m_errs >= 3) begin
              m_locked = 0; m_hunt = 0;
            end
          end else if (m_pmode) begin
            m_errs = 0;
          end
          fq.delete();
          m_pmode = par_en;
        end
      end
    end
  endtask

  // One clock: advance the model, compare all outputs, log deliveries.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_apply();
      tests++;
      if (data_out !== m_data || data_valid !== m_dv || par_err !== m_pe || locked !== m_locked) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t: got data=%h dv=%b pe=%b lk=%b, expected data=%h dv=%b pe=%b lk=%b",
                 $time, data_out, data_valid, par_err, locked, m_data, m_dv, m_pe, m_locked);
      end
      if (data_valid) got_q.push_back({par_err, data_out});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end else begin
      $display("[TB] ok %s = %h", name, got);
    end
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_bit(input logic b);
    step();
    ser_in = b; bit_valid = 1'b1; realign = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bit_valid = 1'b0; realign = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      send_bit(v[i]);
    end
  endtask

  task automatic do_realign();
    step();
    bit_valid = 1'b0; realign = 1'b1;
    step();
    realign = 1'b0;
  endtask

  initial begin
    logic [7:0] c3;
    logic [7:0] a5;
    c3 = 8'hC3;
    a5 = 8'hA5;

    // 1: reset values, async reset mid-frame, no lock without a sync word
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_data", 32'(data_out), 0);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    idle(1);
    chk("t1_data", 32'(data_out), 32'h3C);
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    #2 rst = 1'b1;
    #1;
    chk("async_data", 32'(data_out), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_dv", 32'(data_valid), 0);
    step();
    rst = 1'b0; bit_valid = 1'b0;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h3C, 0);
    idle(1);
    chk("t1_nolock", 32'(locked), 0);
    exp_q.push_back(9'h03C);
    check_log("t1_log");

    // 2: lock and deliver without parity
    send_byte(8'hA5, 0);
    idle(1);
    chk("t2_locked", 32'(locked), 1);
    send_byte(8'h3C, 0);
    send_byte(8'hFF, 0);
    idle(2);
    exp_q.push_back(9'h03C); exp_q.push_back(9'h0FF);
    check_log("t2_log");

    // 3: parity good then bad, lock retained
    do_realign();
    par_en = 1'b1;
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0); send_bit(0);
    send_byte(8'h3C, 0); send_bit(1);
    idle(2);
    chk("t3_locked", 32'(locked), 1);
    exp_q.push_back(9'h03C); exp_q.push_back(9'h13C);
    check_log("t3_log");

    // 4: three consecutive parity errors drop lock, then relock
    do_realign();
    send_byte(8'hA5, 0);
    repeat (3) begin
      send_byte(8'h01, 0); send_bit(0);
    end
    idle(1);
    chk("t4_dv", 32'(data_valid), 1);
    chk("t4_pe", 32'(par_err), 1);
    chk("t4_unlocked", 32'(locked), 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    idle(1);
    chk("t4_relock", 32'(locked), 1);
    send_byte(8'h81, 0); send_bit(0);
    idle(2);
    repeat (3) exp_q.push_back(9'h101);
    exp_q.push_back(9'h081);
    check_log("t4_log");

    // 5: idle gaps inside frames, sync-valued data while locked
    par_en = 1'b0;
    do_realign();
    send_byte(8'hA5, 1);
    send_byte(8'h12, 1);
    send_byte(8'hA5, 1);
    send_byte(8'h7E, 1);
    idle(2);
    chk("t5_locked", 32'(locked), 1);
    exp_q.push_back(9'h012); exp_q.push_back(9'h0A5); exp_q.push_back(9'h07E);
    check_log("t5_log");

    // 6: realign on the final bit, then junk prefix before sync
    do_realign();
    send_byte(8'hA5, 0);
    for (int i = 7; i >= 1; i--) send_bit(c3[i]);
    step();
    ser_in = c3[0]; bit_valid = 1'b1; realign = 1'b1;
    step();
    bit_valid = 1'b0; realign = 1'b0;
    chk("t6_no_dv", 32'(data_valid), 0);
    chk("t6_unlocked", 32'(locked), 0);
    send_bit(1); send_bit(0); send_bit(1);
    for (int i = 7; i >= 1; i--) send_bit(a5[i]);
    idle(1);
    chk("t6_partial", 32'(locked), 0);
    send_bit(a5[0]);
    idle(1);
    chk("t6_locked", 32'(locked), 1);
    send_byte(8'h55, 0);
    idle(2);
    exp_q.push_back(9'h055);
    check_log("t6_log");

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
